// File: rtl/bcd_report_sched.sv
// rtl/bcd_report_sched.sv - round-robin shared binary-to-BCD converter streaming "<tag>:<decimal>\r\n" frames
module bcd_report_sched #(
   parameter int           NREQ     = 3,
   parameter int           WIDTH    = 32,
   parameter int           DIGITS   = 10,
   parameter logic [7:0]   TAG_BASE = 8'h41
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   val,
   output logic [NREQ-1:0]         gnt,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    busy
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = 4 * DIGITS;

   // log2(10) ~= 3.32193: enough digits must exist for the largest WIDTH-bit value
   if (DIGITS * 332193 <= WIDTH * 100000) begin : g_digits_check
      $error("bcd_report_sched: DIGITS too small for WIDTH");
   end

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;
   typedef enum logic [2:0] {P_TAG, P_COLON, P_DIG, P_CR, P_LF} phase_t;

   state_t           state, state_n;
   phase_t           phase;
   logic [PW-1:0]    ptr, src, win_idx, ptr_wrap;
   logic             win_found;
   logic [WIDTH-1:0] bin;
   logic [BW-1:0]    bcd, bcd_adj;
   logic [CW-1:0]    cnt;
   logic [DW-1:0]    dig, msd;
   logic [3:0]       nib_dig, nib_next;
   int               rr_j;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      rr_j      = 0;
      for (int k = 0; k < NREQ; k++) begin
         rr_j = int'(ptr) + k;
         if (rr_j >= NREQ) rr_j = rr_j - NREQ;
         if (!win_found && req[rr_j]) begin
            win_found = 1'b1;
            win_idx   = PW'(rr_j);
         end
      end
      ptr_wrap = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
   end

   always_comb begin
      bcd_adj = '0;
      msd     = '0;
      for (int d = 0; d < DIGITS; d++) begin
         bcd_adj[4*d +: 4] = (bcd[4*d +: 4] > 4'd4) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
         if (bcd[4*d +: 4] != 4'd0) msd = DW'(d);
      end
      nib_dig  = bcd[{dig, 2'b00} +: 4];
      nib_next = bcd[{dig - 1'b1, 2'b00} +: 4];
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (win_found) state_n = CONV;
         CONV:    if (cnt == CW'(WIDTH - 1)) state_n = SEND;
         SEND:    if (tx_valid && tx_ready && phase == P_LF) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt      <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         ptr      <= '0;
         src      <= '0;
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         dig      <= '0;
         phase    <= P_TAG;
      end else begin
         gnt <= '0;
         case (state)
            IDLE: if (win_found) begin
               bin  <= val[win_idx*WIDTH +: WIDTH];
               bcd  <= '0;
               cnt  <= '0;
               src  <= win_idx;
               gnt  <= NREQ'(1) << win_idx;
               busy <= 1'b1;
               ptr  <= ptr_wrap;
            end
            CONV: begin
               bcd <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
               bin <= bin << 1;
               cnt <= cnt + 1'b1;
            end
            SEND: if (!tx_valid) begin
               // first SEND cycle: present the tag and latch the leading significant digit
               tx_valid <= 1'b1;
               tx_data  <= TAG_BASE + 8'(src);
               phase    <= P_TAG;
               dig      <= msd;
            end else if (tx_ready) begin
               case (phase)
                  P_TAG: begin
                     tx_data <= 8'h3A;
                     phase   <= P_COLON;
                  end
                  P_COLON: begin
                     tx_data <= {4'h3, nib_dig};
                     phase   <= P_DIG;
                  end
                  P_DIG: if (dig == '0) begin
                     tx_data <= 8'h0D;
                     phase   <= P_CR;
                  end else begin
                     dig     <= dig - 1'b1;
                     tx_data <= {4'h3, nib_next};
                  end
                  P_CR: begin
                     tx_data <= 8'h0A;
                     phase   <= P_LF;
                  end
                  default: begin
                     tx_valid <= 1'b0;
                     busy     <= 1'b0;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end
endmodule
